// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream of the frame drain engine.
// master = drain engine side, slave = FIFO / stream sink side.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_empty;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains one frame of FRAME_LEN words from a FIFO onto a valid/ready stream, hiding the
// FIFO read latency behind a small skid buffer. FIFO_READER_PATTERN_CHK_EN adds a pattern checker.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           err_cnt,
  fifo_stream_reader_if.master bus
);

  localparam int SKID_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W      = $clog2(SKID_DEPTH);
  localparam int OCC_W      = $clog2(2 * SKID_DEPTH + 1);

  localparam logic [CNT_WIDTH-1:0] FRAME_CNT = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0]     PTR_MAX   = PTR_W'(SKID_DEPTH - 1);
  localparam logic [OCC_W-1:0]     OCC_MAX   = OCC_W'(SKID_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  run, accept, rd_en, push, pop, valid, last_xfer;
  logic [CNT_WIDTH-1:0]  issued_cnt, sent_cnt;
  logic [RD_LATENCY-1:0] vpipe;
  logic [OCC_W-1:0]      inflight, skid_cnt, occ;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_xfer) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    run    = (state == S_RUN);
    accept = (state == S_IDLE) && start;
  end

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) inflight = inflight + OCC_W'(vpipe[i]);
  end

  // Credit uses registered occupancy only; the spare skid entry absorbs a same-cycle pop.
  assign occ   = inflight + skid_cnt;
  assign rd_en = run && !bus.fifo_rd_empty && (issued_cnt < FRAME_CNT) && (occ < OCC_MAX);

  assign push      = vpipe[RD_LATENCY-1];
  assign valid     = (skid_cnt != '0);
  assign pop       = valid && bus.m_ready;
  assign last_xfer = pop && (sent_cnt == LAST_IDX);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = skid_mem[rd_ptr];
  assign bus.m_last     = valid && (sent_cnt == LAST_IDX);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= rd_en;
      for (int unsigned i = 1; i < RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      issued_cnt <= '0;
      sent_cnt   <= '0;
    end else if (accept) begin
      issued_cnt <= '0;
      sent_cnt   <= '0;
    end else begin
      if (rd_en) issued_cnt <= issued_cnt + 1'b1;
      if (pop)   sent_cnt   <= sent_cnt + 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skid_cnt <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
    end else begin
      if (push) begin
        skid_mem[wr_ptr] <= bus.fifo_rd_data;
        wr_ptr           <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   skid_cnt <= skid_cnt + 1'b1;
        2'b01:   skid_cnt <= skid_cnt - 1'b1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

`ifdef FIFO_READER_PATTERN_CHK_EN
  logic [DATA_WIDTH-1:0] exp_word;

  always_ff @(posedge rd_clk) begin
    if (rd_rst || accept) begin
      exp_word <= '1;
      err_cnt  <= '0;
    end else if (pop) begin
      exp_word <= exp_word - 1'b1;
      if ((bus.m_data != exp_word) && (err_cnt != 3'd7)) err_cnt <= err_cnt + 3'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Runs RD_LATENCY=1 and RD_LATENCY=2 readers in lockstep against FIFO models, with a
// per-lane scoreboard of the words loaded into the FIFO.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int FL = 1024;
  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          flush = 1'b1;
  logic [11:0]   wptr  = '0;
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] exp0 [$];
  logic [DW-1:0] exp1 [$];

  logic [1:0]    vld, last, busy, done, rden, empty, ovf;
  logic [DW-1:0] dat [2];
  logic [2:0]    err [2];

  int tests = 0;
  int fails = 0;
  int xfer [2], done_cnt [2], first_k [2], done_k [2], resume_k [2];
  int gap_end;
  logic [DW-1:0] resume_dat [2];
  logic          stall_prev [2];
  logic [DW-1:0] stall_dat [2];

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;
    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
    logic [11:0]   rptr;
    logic [DW-1:0] d1, d2;

    fifo_stream_reader #(
      .DATA_WIDTH(DW), .RD_LATENCY(LAT), .FRAME_LEN(FL), .CNT_WIDTH(CW)
    ) dut (
      .rd_clk (clk),
      .rd_rst (rst),
      .start  (start),
      .busy   (busy[g]),
      .done   (done[g]),
      .err_cnt(err[g]),
      .bus    (bus)
    );

    always @(posedge clk) begin
      if (flush) rptr <= '0;
      else if (bus.fifo_rd_en) rptr <= rptr + 1'b1;
      if (bus.fifo_rd_en) d1 <= mem[rptr];
      d2 <= d1;
    end

    assign bus.fifo_rd_data  = (LAT == 1) ? d1 : d2;
    assign bus.fifo_rd_empty = (rptr == wptr);
    assign bus.m_ready       = ready;
    assign vld[g]   = bus.m_valid;
    assign last[g]  = bus.m_last;
    assign rden[g]  = bus.fifo_rd_en;
    assign empty[g] = bus.fifo_rd_empty;
    assign dat[g]   = bus.m_data;
    assign ovf[g]   = (int'(dut.skid_cnt) > LAT + 2);
  end

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    wptr  = '0;
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic load_words(input int n, input int first_idx, input int bad_lo, input int bad_hi);
    int idx;
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      idx = first_idx + i;
      w   = DW'(255 - idx);
      if (idx >= bad_lo && idx <= bad_hi) w = '0;
      mem[wptr] = w;
      wptr = wptr + 1'b1;
      exp0.push_back(w);
      exp1.push_back(w);
    end
  endtask

  task automatic clear_stats();
    for (int g = 0; g < 2; g++) begin
      xfer[g] = 0; done_cnt[g] = 0; first_k[g] = -1; done_k[g] = -1;
      resume_k[g] = -1; resume_dat[g] = '0; stall_prev[g] = 1'b0;
    end
    gap_end = -1;
  endtask

  // Called once per cycle after inputs settle; values seen here are what the next edge samples.
  task automatic observe(input int k);
    logic [DW-1:0] e;
    logic have;
    for (int g = 0; g < 2; g++) begin
      if (stall_prev[g]) begin
        tests++;
        if (vld[g] !== 1'b1 || dat[g] !== stall_dat[g]) begin
          fails++;
          $display("FAIL stall_hold lane%0d cyc %0d: valid=%b data=%h, required valid=1 data=%h",
                   g, k, vld[g], dat[g], stall_dat[g]);
        end
      end
      stall_prev[g] = (vld[g] === 1'b1) && !ready;
      stall_dat[g]  = dat[g];
      if (vld[g] === 1'b1 && first_k[g] < 0) first_k[g] = k;
      if (vld[g] === 1'b1 && ready) begin
        have = 1'b0;
        e    = '0;
        if (g == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
        if (g == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
        tests++;
        if (!have || dat[g] !== e) begin
          fails++;
          $display("FAIL data lane%0d word %0d: got %h, required %h (queued=%b)", g, xfer[g], dat[g], e, have);
        end
        tests++;
        if (last[g] !== (xfer[g] == FL - 1)) begin
          fails++;
          $display("FAIL last lane%0d word %0d: got %b, required %b", g, xfer[g], last[g], (xfer[g] == FL - 1));
        end
        xfer[g]++;
      end
      if (empty[g] === 1'b1) begin
        tests++;
        if (rden[g] !== 1'b0) begin
          fails++;
          $display("FAIL rd_en_while_empty lane%0d cyc %0d: fifo_rd_en=%b, required 0", g, k, rden[g]);
        end
      end
      tests++;
      if (ovf[g] !== 1'b0) begin
        fails++;
        $display("FAIL skid_overflow lane%0d cyc %0d: overflow=%b, required 0", g, k, ovf[g]);
      end
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        if (done_k[g] < 0) done_k[g] = k;
      end else if (done_k[g] >= 0 && k <= done_k[g] + 3) begin
        tests++;
        if (busy[g] !== 1'b0) begin
          fails++;
          $display("FAIL busy_after_done lane%0d cyc %0d: busy=%b, required 0", g, k, busy[g]);
        end
      end
    end
  endtask

  // mode 0: ready high, 1: ready toggles, 2: FIFO runs dry after word 300 for 10 cycles.
  // A second start at cycle 100 lands while busy and must be dropped.
  task automatic drive_frame(input int mode, input int max_cyc);
    int k, gap;
    logic fin;
    clear_stats();
    k = 0; gap = -1; fin = 1'b0;
    while (!fin && k < max_cyc) begin
      @(negedge clk);
      start = (k == 0 || k == 100);
      ready = (mode == 1) ? (k % 2 == 0) : 1'b1;
      if (mode == 2) begin
        if (gap < 0 && xfer[0] == 300 && xfer[1] == 300) gap = 0;
        if (gap == 10) begin
          load_words(FL - 300, 300, -1, -1);
          gap_end = k - 1;
          gap = 11;
        end
      end
      #1;
      if (mode == 2 && gap >= 0 && gap < 10) begin
        for (int g = 0; g < 2; g++) begin
          tests++;
          if (vld[g] !== 1'b0) begin
            fails++;
            $display("FAIL gap_valid lane%0d cyc %0d: m_valid=%b, required 0", g, k, vld[g]);
          end
        end
        gap++;
      end
      if (mode == 2 && gap == 11) begin
        for (int g = 0; g < 2; g++)
          if (resume_k[g] < 0 && vld[g] === 1'b1) begin resume_k[g] = k; resume_dat[g] = dat[g]; end
      end
      observe(k);
      fin = (done_k[0] >= 0) && (done_k[1] >= 0) && (k >= done_k[0] + 3) && (k >= done_k[1] + 3);
      k++;
    end
    start = 1'b0;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL frame_timeout mode %0d: done lane0=%0d lane1=%0d after %0d cycles, required both", mode, done_cnt[0], done_cnt[1], k);
    end
  endtask

  task automatic check_complete(input string tag);
    for (int g = 0; g < 2; g++) begin
      tests++;
      if (xfer[g] != FL || done_cnt[g] != 1 || (g == 0 ? exp0.size() : exp1.size()) != 0) begin
        fails++;
        $display("FAIL %s_complete lane%0d: words=%0d done=%0d left=%0d, required %0d/1/0",
                 tag, g, xfer[g], done_cnt[g], (g == 0 ? exp0.size() : exp1.size()), FL);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      tests++;
      if ({vld[g], last[g], busy[g], done[g], rden[g]} !== 5'b0 || dat[g] !== '0 || err[g] !== 3'd0) begin
        fails++;
        $display("FAIL reset_outputs lane%0d: v/l/b/d/r=%b%b%b%b%b data=%h err=%0d, required all 0",
                 g, vld[g], last[g], busy[g], done[g], rden[g], dat[g], err[g]);
      end
    end
  endtask

  task automatic test_nominal();
    do_flush();
    load_words(FL, 0, -1, -1);
    drive_frame(0, 1300);
    check_complete("nominal");
    for (int g = 0; g < 2; g++) begin
      tests++;
      if (first_k[g] != g + 3) begin
        fails++;
        $display("FAIL first_valid lane%0d: cycle %0d, required %0d", g, first_k[g], g + 3);
      end
      tests++;
      if (done_k[g] != g + 3 + FL) begin
        fails++;
        $display("FAIL done_cycle lane%0d: cycle %0d, required %0d", g, done_k[g], g + 3 + FL);
      end
      tests++;
      if (err[g] !== 3'd0) begin
        fails++;
        $display("FAIL nominal_err lane%0d: err_cnt=%0d, required 0", g, err[g]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_flush();
    load_words(FL, 0, -1, -1);
    drive_frame(1, 2600);
    check_complete("backpressure");
  endtask

  task automatic test_empty_stall();
    do_flush();
    load_words(300, 0, -1, -1);
    drive_frame(2, 1400);
    check_complete("empty_stall");
    for (int g = 0; g < 2; g++) begin
      tests++;
      if (resume_dat[g] !== 8'hD3 || resume_k[g] - gap_end != g + 3) begin
        fails++;
        $display("FAIL resume lane%0d: data=%h after %0d cycles, required d3 after %0d",
                 g, resume_dat[g], resume_k[g] - gap_end, g + 3);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    do_flush();
    load_words(FL, 0, -1, -1);
    clear_stats();
    k = 0;
    while (xfer[0] < 500 && k < 1000) begin
      @(negedge clk);
      start = (k == 0);
      ready = 1'b1;
      #1;
      observe(k);
      k++;
    end
    tests++;
    if (xfer[0] != 500) begin
      fails++;
      $display("FAIL reset_reach: words=%0d, required 500", xfer[0]);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      tests++;
      if ({vld[g], last[g], busy[g], done[g], rden[g]} !== 5'b0 || dat[g] !== '0 || err[g] !== 3'd0) begin
        fails++;
        $display("FAIL midreset_outputs lane%0d: v/l/b/d/r=%b%b%b%b%b data=%h err=%0d, required all 0",
                 g, vld[g], last[g], busy[g], done[g], rden[g], dat[g], err[g]);
      end
    end
    rst = 1'b0;
    do_flush();
    load_words(FL, 0, -1, -1);
    drive_frame(0, 1300);
    check_complete("after_reset");
  endtask

  task automatic test_checker();
    logic [2:0] want1, want9;
`ifdef FIFO_READER_PATTERN_CHK_EN
    want1 = 3'd1;
    want9 = 3'd7;
`else
    want1 = 3'd0;
    want9 = 3'd0;
`endif
    do_flush();
    load_words(FL, 0, 9, 9);
    drive_frame(0, 1300);
    for (int g = 0; g < 2; g++) begin
      tests++;
      if (err[g] !== want1) begin
        fails++;
        $display("FAIL err_one lane%0d: err_cnt=%0d, required %0d", g, err[g], want1);
      end
    end
    do_flush();
    load_words(FL, 0, 20, 28);
    drive_frame(0, 1300);
    for (int g = 0; g < 2; g++) begin
      tests++;
      if (err[g] !== want9) begin
        fails++;
        $display("FAIL err_sat lane%0d: err_cnt=%0d, required %0d", g, err[g], want9);
      end
    end
  endtask

  initial begin
    do_flush();
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_nominal();
    test_backpressure();
    test_empty_stall();
    test_reset_mid_frame();
    test_checker();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
